bounded_queue_mem: RTL
======================

# bounded_queue_mem

Parametrised bounded queue built on an unpacked-array memory. It is the next generation of the fixed-size memory and `[$:N]` queue constructs in the frontend array test suite, used as a synthesizable, cycle-accurate reference for lowering tests. It supports runtime FIFO/LIFO mode, valid/ready handshakes on both ports, occupancy and error flags, and an optional random-access peek port.

## Interface
- `WIDTH`, 8, data bits per entry
- `DEPTH`, 11, number of entries (max index `DEPTH-1`); any value ≥2, not restricted to a power of two
- `CW`, `$clog2(DEPTH+1)`, count width (derived, not overridden)

- `clk`  in  1  single clock; all state updates on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `lifo`  in  1  mode request: 0 = FIFO, 1 = LIFO
- `push_valid`  in  1  write request
- `push_ready`  out  1  `!full`
- `push_data`  in  WIDTH  write data
- `pop_valid`  out  1  `!empty`
- `pop_ready`  in  1  read acknowledge
- `pop_data`  out  WIDTH  head entry (show-ahead); 0 when empty
- `count`  out  CW  occupancy, 0..DEPTH
- `full`, `empty`  out  1  `count==DEPTH`, `count==0`
- `overflow`, `underflow`  out  1  sticky error flags
- `peek_idx`  in  CW  logical index from head (only with `BOUNDED_QUEUE_PEEK_EN`)
- `peek_data`  out  WIDTH  registered peek result (only with the macro)
- `peek_hit`  out  1  registered: `peek_idx < count` (only with the macro)

## Operation
- Push fires when `push_valid && push_ready`. Pop fires when `pop_valid && pop_ready`.
- Mode register `mode_q`:
  - loads `lifo` on any cycle where `empty && !push fire`;
  - holds while non-empty.
  - On each load, `rd_ptr` and `wr_ptr` are cleared to 0.
- FIFO mode:
  - write at `wr_ptr`; head at `rd_ptr`;
  - each pointer advances by 1 and wraps from `DEPTH-1` to 0 (explicit compare, no modulo-2^n).
- LIFO mode:
  - write at `count`; head (top) at `count-1`;
  - push and pop in the same cycle overwrites slot `count-1` with `push_data`, and `count` is unchanged.
- Count update:
  - push only: +1;
  - pop only: −1;
  - both: unchanged.
  - Push is never accepted when full, and pop is never valid when empty.
- `overflow` sets on `push_valid && !push_ready`. `underflow` sets on `pop_ready && !pop_valid`. Both clear only on `rst`.
- Memory contents are not reset; unwritten entries are never presented on `pop_data`.

## Timing
- Reset values:
  - `count=0`, `empty=1`, `full=0`, `push_ready=1`, `pop_valid=0`, `pop_data=0`;
  - `overflow=0`, `underflow=0`, `mode_q=0` (FIFO), pointers 0;
  - `peek_data=0`, `peek_hit=0`.
- Push-to-pop latency is 1 cycle: data pushed at edge N appears on `pop_data`, with `pop_valid=1`, after edge N.
- `pop_data`, `full`, `empty`, `push_ready`, and `pop_valid` are combinational from registered state only. There is no input→output combinational path.
- `rst` asserted mid-operation discards all entries on that edge. Push or pop in the same cycle as `rst` is ignored.
- Peek (macro only) has 1-cycle latency:
  - it samples `peek_idx` against the pre-edge state;
  - physical slot is `(rd_ptr+idx)` wrapped (FIFO) or `count-1-idx` (LIFO);
  - on a miss, `peek_hit=0` and `peek_data=0`.

## Configuration
- `BOUNDED_QUEUE_PEEK_EN` defined: the `peek_idx`, `peek_data` and `peek_hit` ports and their logic are present.
- Not defined: those ports are absent. All other behaviour is identical.

## Test plan
- Reset, then FIFO with `DEPTH=11`: push 0x00..0x0A → `full=1`, `push_ready=0`. Pop all → 0x00..0x0A in order, then `empty=1`.
- FIFO wrap-around: push 6 entries, pop 6, push 0x10..0x19 → pops return 0x10..0x19, with the pointers crossing slot 10→0.
- LIFO with `lifo=1` while empty: push 0xA1, 0xB2, 0xC3 → pops return 0xC3, 0xB2, 0xA1. Simultaneous push 0xEE/pop at `count=2` → pop sees 0xB2, `count` stays 2, next pop returns 0xEE.
- Errors:
  - push when full → `overflow=1` and it persists;
  - pop when empty → `underflow=1`;
  - toggling `lifo` while non-empty → order unchanged.
- Mid-stream `rst` with `count=5` → the next cycle has `count=0`, `empty=1`, both flags 0, mode FIFO.
- With the macro: FIFO holding 0x30..0x34 and `peek_idx=2` → next cycle `peek_hit=1`, `peek_data=0x32`. `peek_idx=7` → `peek_hit=0`, `peek_data=0`.

Source files
------------

// File: rtl/bounded_queue_mem.sv
// Bounded FIFO/LIFO queue on an unpacked-array memory with valid/ready ports and sticky error flags.
// Optional registered random-access peek port is enabled by defining BOUNDED_QUEUE_PEEK_EN.
module bounded_queue_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 11,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             lifo,
    input  logic             push_valid,
    output logic             push_ready,
    input  logic [WIDTH-1:0] push_data,
    output logic             pop_valid,
    input  logic             pop_ready,
    output logic [WIDTH-1:0] pop_data,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty,
    output logic             overflow,
    output logic             underflow
`ifdef BOUNDED_QUEUE_PEEK_EN
    ,
    input  logic [CW-1:0]    peek_idx,
    output logic [WIDTH-1:0] peek_data,
    output logic             peek_hit
`endif
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [AW-1:0] LAST_C  = AW'(DEPTH - 1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    rd_ptr_r;
    logic [AW-1:0]    wr_ptr_r;
    logic [CW-1:0]    count_r;
    logic             mode_r;
    logic             overflow_r;
    logic             underflow_r;

    logic             full_s;
    logic             empty_s;
    logic             push_fire_s;
    logic             pop_fire_s;
    logic [CW-1:0]    cnt_m1_s;
    logic [AW-1:0]    top_addr_s;
    logic [AW-1:0]    head_addr_s;
    logic [AW-1:0]    wr_addr_s;
    logic [AW-1:0]    rd_ptr_nxt_s;
    logic [AW-1:0]    wr_ptr_nxt_s;

    // Status, handshake and address decode derived from registered state.
    always_comb begin
        full_s       = (count_r == DEPTH_C);
        empty_s      = (count_r == {CW{1'b0}});
        push_fire_s  = push_valid && !full_s;
        pop_fire_s   = pop_ready && !empty_s;
        cnt_m1_s     = count_r - {{(CW-1){1'b0}}, 1'b1};
        top_addr_s   = cnt_m1_s[AW-1:0];
        rd_ptr_nxt_s = (rd_ptr_r == LAST_C) ? {AW{1'b0}} : rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
        wr_ptr_nxt_s = (wr_ptr_r == LAST_C) ? {AW{1'b0}} : wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
        if (mode_r) begin
            head_addr_s = top_addr_s;
            // A simultaneous LIFO push/pop replaces the current top in place.
            if (pop_fire_s) begin
                wr_addr_s = top_addr_s;
            end else begin
                wr_addr_s = count_r[AW-1:0];
            end
        end else begin
            head_addr_s = rd_ptr_r;
            wr_addr_s   = wr_ptr_r;
        end
    end

    // Show-ahead head entry; never exposes memory while empty.
    always_comb begin
        if (empty_s) begin
            pop_data = {WIDTH{1'b0}};
        end else begin
            pop_data = mem_r[head_addr_s];
        end
    end

    assign push_ready = !full_s;
    assign pop_valid  = !empty_s;
    assign full       = full_s;
    assign empty      = empty_s;
    assign count      = count_r;
    assign overflow   = overflow_r;
    assign underflow  = underflow_r;

    // Mode, pointers, occupancy and sticky error flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_r      <= 1'b0;
            rd_ptr_r    <= {AW{1'b0}};
            wr_ptr_r    <= {AW{1'b0}};
            count_r     <= {CW{1'b0}};
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            if (empty_s && !push_fire_s) begin
                mode_r   <= lifo;
                rd_ptr_r <= {AW{1'b0}};
                wr_ptr_r <= {AW{1'b0}};
            end else if (!mode_r) begin
                if (push_fire_s) begin
                    wr_ptr_r <= wr_ptr_nxt_s;
                end
                if (pop_fire_s) begin
                    rd_ptr_r <= rd_ptr_nxt_s;
                end
            end
            case ({push_fire_s, pop_fire_s})
                2'b10:   count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
                2'b01:   count_r <= cnt_m1_s;
                default: count_r <= count_r;
            endcase
            if (push_valid && full_s) begin
                overflow_r <= 1'b1;
            end
            if (pop_ready && empty_s) begin
                underflow_r <= 1'b1;
            end
        end
    end

    // Storage array; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (!rst && push_fire_s) begin
            mem_r[wr_addr_s] <= push_data;
        end
    end

`ifdef BOUNDED_QUEUE_PEEK_EN
    logic [CW:0]      peek_sum_s;
    logic [CW:0]      peek_wrap_s;
    logic [CW-1:0]    peek_lifo_s;
    logic [AW-1:0]    peek_addr_s;
    logic             peek_hit_s;
    logic [WIDTH-1:0] peek_data_r;
    logic             peek_hit_r;

    // Logical peek index to physical slot; idx < count keeps the sum below 2*DEPTH.
    always_comb begin
        peek_sum_s  = {{(CW-AW+1){1'b0}}, rd_ptr_r} + {1'b0, peek_idx};
        peek_lifo_s = cnt_m1_s - peek_idx;
        peek_hit_s  = (peek_idx < count_r);
        if (peek_sum_s >= {1'b0, DEPTH_C}) begin
            peek_wrap_s = peek_sum_s - {1'b0, DEPTH_C};
        end else begin
            peek_wrap_s = peek_sum_s;
        end
        if (mode_r) begin
            peek_addr_s = peek_lifo_s[AW-1:0];
        end else begin
            peek_addr_s = peek_wrap_s[AW-1:0];
        end
    end

    // Registered peek result, zeroed on a miss.
    always_ff @(posedge clk) begin
        if (rst) begin
            peek_data_r <= {WIDTH{1'b0}};
            peek_hit_r  <= 1'b0;
        end else begin
            peek_hit_r  <= peek_hit_s;
            peek_data_r <= peek_hit_s ? mem_r[peek_addr_s] : {WIDTH{1'b0}};
        end
    end

    assign peek_data = peek_data_r;
    assign peek_hit  = peek_hit_r;
`endif

endmodule
